// File: rtl/data_tape.sv
// Pointer-addressed data tape: a zeroing sweep (CLEAR) followed by pointer ops and edge-triggered writes.
// Optional macro DATA_TAPE_BOUND_CHECK_EN saturates pointer arithmetic and raises a sticky err.
module data_tape #(
    parameter int unsigned DATA_BITWIDTH = 8,
    parameter int unsigned CODE_BITWIDTH = 16,
    parameter int unsigned TAPE_AW       = 10,
    parameter logic [1:0]  ADDR_NOP      = 2'h0,
    parameter logic [1:0]  ADDR_MOD      = 2'h1,
    parameter logic [1:0]  ADDR_SET      = 2'h2,
    parameter logic [1:0]  ADDR_RST      = 2'h3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [1:0]               flag_op_addr,
    input  logic [CODE_BITWIDTH-1:0] code,
    input  logic [DATA_BITWIDTH-1:0] data_in,
    input  logic                     data_wr,
    input  logic                     clr,
    output logic [DATA_BITWIDTH-1:0] data,
    output logic [TAPE_AW-1:0]       addr,
    output logic                     ready,
    output logic                     err
);

    localparam int unsigned Depth = 2 ** TAPE_AW;
    localparam int unsigned ExtW  = TAPE_AW + 9;
    localparam logic [TAPE_AW-1:0] PtrMax = '1;

    typedef enum logic [0:0] {StClear, StRun} state_e;

    state_e                   state_q, state_d;
    logic [TAPE_AW-1:0]       sweep_q, sweep_d;
    logic [TAPE_AW-1:0]       ptr_q, ptr_d;
    logic                     wr_hist_q;
    logic [DATA_BITWIDTH-1:0] data_q, data_d;
    logic [DATA_BITWIDTH-1:0] mem [Depth];

    logic                     wr_en;
    logic [TAPE_AW-1:0]       wr_addr;
    logic [DATA_BITWIDTH-1:0] wr_data;

    logic [ExtW-1:0]          ptr_ext, imm_ext, mod_sum;
    logic [TAPE_AW-1:0]       mod_ptr;
    logic                     unused_code;

    assign ptr_ext     = {{9{1'b0}}, ptr_q};
    assign imm_ext     = {{(ExtW - 8){1'b0}}, code[11:4]};
    assign unused_code = ^{code[14:12], code[3:0]};

`ifdef DATA_TAPE_BOUND_CHECK_EN
    logic err_q, err_d;
    logic mod_sat;

    always_comb begin
        mod_sum = code[15] ? (ptr_ext - imm_ext) : (ptr_ext + imm_ext);
        mod_ptr = mod_sum[TAPE_AW-1:0];
        mod_sat = 1'b0;
        if (code[15] && (imm_ext > ptr_ext)) begin
            mod_ptr = '0;
            mod_sat = 1'b1;
        end else if (!code[15] && (|mod_sum[ExtW-1:TAPE_AW])) begin
            mod_ptr = PtrMax;
            mod_sat = 1'b1;
        end
    end

    assign err = err_q;
`else
    logic unused_mod;

    // Wrapping arithmetic: only the low TAPE_AW bits of the sum matter.
    always_comb begin
        mod_sum = code[15] ? (ptr_ext - imm_ext) : (ptr_ext + imm_ext);
        mod_ptr = mod_sum[TAPE_AW-1:0];
    end

    assign unused_mod = ^mod_sum[ExtW-1:TAPE_AW];
    assign err        = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        ptr_d   = ptr_q;
        wr_en   = 1'b0;
        wr_addr = ptr_q;
        wr_data = data_in;
`ifdef DATA_TAPE_BOUND_CHECK_EN
        err_d   = err_q;
`endif
        case (state_q)
            StClear: begin
                wr_en   = 1'b1;
                wr_addr = sweep_q;
                wr_data = '0;
                sweep_d = sweep_q + 1'b1;
                if (sweep_q == PtrMax) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (clr) begin
                    // Re-zero takes priority over any same-cycle pointer op or write.
                    state_d = StClear;
                    sweep_d = '0;
                    ptr_d   = '0;
`ifdef DATA_TAPE_BOUND_CHECK_EN
                    err_d   = 1'b0;
`endif
                end else begin
                    wr_en = data_wr & ~wr_hist_q;
                    case (flag_op_addr)
                        ADDR_MOD: begin
                            ptr_d = mod_ptr;
`ifdef DATA_TAPE_BOUND_CHECK_EN
                            if (mod_sat) begin
                                err_d = 1'b1;
                            end
`endif
                        end
                        ADDR_SET: ptr_d = imm_ext[TAPE_AW-1:0];
                        ADDR_RST: ptr_d = '0;
                        default:  ptr_d = ptr_q;
                    endcase
                end
            end
            default: state_d = StClear;
        endcase
    end

    // Read the cell under the next pointer, forwarding a same-edge write to that cell.
    always_comb begin
        data_d = '0;
        if (state_d == StRun) begin
            if (wr_en && (wr_addr == ptr_d)) begin
                data_d = wr_data;
            end else begin
                data_d = mem[ptr_d];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StClear;
            sweep_q   <= '0;
            ptr_q     <= '0;
            wr_hist_q <= 1'b0;
            data_q    <= '0;
`ifdef DATA_TAPE_BOUND_CHECK_EN
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            sweep_q   <= sweep_d;
            ptr_q     <= ptr_d;
            wr_hist_q <= data_wr;
            data_q    <= data_d;
`ifdef DATA_TAPE_BOUND_CHECK_EN
            err_q     <= err_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign data  = data_q;
    assign addr  = ptr_q;
    assign ready = (state_q == StRun);

endmodule

// File: tb/tb_data_tape.sv
// Scoreboard bench for data_tape with TAPE_AW=4: stimulus pushes cycle-tagged expectations,
// a monitor compares them against the outputs shortly after each rising edge.
module tb_data_tape;

    localparam logic [1:0] OpNop = 2'h0;
    localparam logic [1:0] OpMod = 2'h1;
    localparam logic [1:0] OpSet = 2'h2;
    localparam logic [1:0] OpRst = 2'h3;

`ifdef DATA_TAPE_BOUND_CHECK_EN
    localparam bit BoundChk = 1'b1;
`else
    localparam bit BoundChk = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  flag_op_addr = OpNop;
    logic [15:0] code = '0;
    logic [7:0]  data_in = '0;
    logic        data_wr = 1'b0;
    logic        clr = 1'b0;
    logic [7:0]  data;
    logic [3:0]  addr;
    logic        ready;
    logic        err;

    data_tape #(
        .DATA_BITWIDTH(8),
        .CODE_BITWIDTH(16),
        .TAPE_AW(4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flag_op_addr(flag_op_addr),
        .code        (code),
        .data_in     (data_in),
        .data_wr     (data_wr),
        .clr         (clr),
        .data        (data),
        .addr        (addr),
        .ready       (ready),
        .err         (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        int         due;
        logic [3:0] addr;
        logic [7:0] data;
        logic       rdy;
        logic       err;
    } exp_t;

    exp_t  sb[$];
    string sb_name[$];
    int    cyc = 0;
    int    tests = 0;
    int    fails = 0;

    function automatic logic [15:0] mk(input logic minus, input logic [7:0] imm);
        return {minus, 3'b000, imm, 4'b0000};
    endfunction

    task automatic tick(input logic [1:0] op, input logic [15:0] c, input logic [7:0] din,
                        input logic wr, input logic cl);
        @(negedge clk);
        flag_op_addr = op;
        code         = c;
        data_in      = din;
        data_wr      = wr;
        clr          = cl;
    endtask

    task automatic expect_at(input string nm, input int lead, input logic [3:0] a,
                             input logic [7:0] d, input logic r, input logic e);
        exp_t x;
        x.due  = cyc + lead;
        x.addr = a;
        x.data = d;
        x.rdy  = r;
        x.err  = e;
        sb.push_back(x);
        sb_name.push_back(nm);
    endtask

    // Monitor: compare every expectation that falls due on this edge.
    initial begin
        forever begin
            exp_t  x;
            string nm;
            @(posedge clk);
            cyc = cyc + 1;
            #1;
            while (sb.size() > 0 && sb[0].due <= cyc) begin
                x  = sb.pop_front();
                nm = sb_name.pop_front();
                tests++;
                if (x.due != cyc || addr !== x.addr || data !== x.data || ready !== x.rdy
                    || err !== x.err) begin
                    fails++;
                    $display("FAIL %s @cyc %0d: got addr=%0h data=%0h ready=%0b err=%0b, want addr=%0h data=%0h ready=%0b err=%0b",
                             nm, cyc, addr, data, ready, err, x.addr, x.data, x.rdy, x.err);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        tick(OpNop, '0, 8'h00, 1'b0, 1'b0);
        expect_at("reset_state", 1, 4'h0, 8'h00, 1'b0, 1'b0);
        tick(OpNop, '0, 8'h00, 1'b0, 1'b0);

        // Release reset: 16 sweep edges, ready on the 16th.
        @(negedge clk);
        rst_n = 1'b1;
        expect_at("clear_busy", 15, 4'h0, 8'h00, 1'b0, 1'b0);
        expect_at("ready_rise", 16, 4'h0, 8'h00, 1'b1, 1'b0);
        repeat (15) tick(OpNop, '0, 8'h00, 1'b0, 1'b0);

        tick(OpSet, mk(1'b0, 8'h05), 8'h00, 1'b0, 1'b0);
        expect_at("set5", 1, 4'h5, 8'h00, 1'b1, 1'b0);
        tick(OpNop, '0, 8'hA7, 1'b1, 1'b0);
        expect_at("write_a7", 1, 4'h5, 8'hA7, 1'b1, 1'b0);
        tick(OpNop, '0, 8'h00, 1'b0, 1'b0);

        tick(OpSet, mk(1'b0, 8'h09), 8'h00, 1'b0, 1'b0);
        expect_at("set9", 1, 4'h9, 8'h00, 1'b1, 1'b0);
        tick(OpNop, '0, 8'h11, 1'b1, 1'b0);
        expect_at("hold_wr_11", 1, 4'h9, 8'h11, 1'b1, 1'b0);
        tick(OpNop, '0, 8'h22, 1'b1, 1'b0);
        expect_at("hold_wr_22", 1, 4'h9, 8'h11, 1'b1, 1'b0);
        tick(OpNop, '0, 8'h33, 1'b1, 1'b0);
        expect_at("hold_wr_33", 1, 4'h9, 8'h11, 1'b1, 1'b0);
        tick(OpNop, '0, 8'h00, 1'b0, 1'b0);

        tick(OpSet, mk(1'b0, 8'h03), 8'h00, 1'b0, 1'b0);
        expect_at("set3", 1, 4'h3, 8'h00, 1'b1, 1'b0);
        tick(OpMod, mk(1'b0, 8'h01), 8'h5C, 1'b1, 1'b0);
        expect_at("wr_and_inc", 1, 4'h4, 8'h00, 1'b1, 1'b0);
        tick(OpSet, mk(1'b0, 8'h03), 8'h00, 1'b0, 1'b0);
        expect_at("read3_5c", 1, 4'h3, 8'h5C, 1'b1, 1'b0);
        tick(OpMod, mk(1'b0, 8'h00), 8'h66, 1'b1, 1'b0);
        expect_at("bypass_66", 1, 4'h3, 8'h66, 1'b1, 1'b0);
        tick(OpNop, '0, 8'h00, 1'b0, 1'b0);
        expect_at("nop_hold", 1, 4'h3, 8'h66, 1'b1, 1'b0);
        tick(OpSet, mk(1'b0, 8'h05), 8'h00, 1'b0, 1'b0);
        expect_at("read5_a7", 1, 4'h5, 8'hA7, 1'b1, 1'b0);
        tick(OpSet, mk(1'b0, 8'h09), 8'h00, 1'b0, 1'b0);
        expect_at("read9_11", 1, 4'h9, 8'h11, 1'b1, 1'b0);

        tick(OpRst, '0, 8'h00, 1'b0, 1'b0);
        expect_at("ptr_rst", 1, 4'h0, 8'h00, 1'b1, 1'b0);
        tick(OpMod, mk(1'b1, 8'h02), 8'h00, 1'b0, 1'b0);
        expect_at("under_m2", 1, BoundChk ? 4'h0 : 4'hE, 8'h00, 1'b1, BoundChk);
        tick(OpSet, mk(1'b0, 8'h0E), 8'h00, 1'b0, 1'b0);
        expect_at("set14_sticky", 1, 4'hE, 8'h00, 1'b1, BoundChk);
        tick(OpMod, mk(1'b0, 8'h03), 8'h00, 1'b0, 1'b0);
        expect_at("over_p3", 1, BoundChk ? 4'hF : 4'h1, 8'h00, 1'b1, BoundChk);

        tick(OpNop, '0, 8'h00, 1'b0, 1'b1);
        expect_at("clr_enter", 1, 4'h0, 8'h00, 1'b0, 1'b0);
        // Ops, write and clr during the sweep must all be ignored.
        tick(OpSet, mk(1'b0, 8'h05), 8'hFF, 1'b1, 1'b1);
        expect_at("clear_ignore", 1, 4'h0, 8'h00, 1'b0, 1'b0);
        expect_at("clr_busy", 15, 4'h0, 8'h00, 1'b0, 1'b0);
        expect_at("clr_ready", 16, 4'h0, 8'h00, 1'b1, 1'b0);
        repeat (15) tick(OpNop, '0, 8'h00, 1'b0, 1'b0);

        for (int i = 0; i < 16; i++) begin
            tick(OpSet, mk(1'b0, 8'(i)), 8'h00, 1'b0, 1'b0);
            expect_at($sformatf("zero_cell%0d", i), 1, 4'(i), 8'h00, 1'b1, 1'b0);
        end
        tick(OpNop, '0, 8'h00, 1'b0, 1'b0);
        repeat (3) @(negedge clk);

        tests++;
        if (ready !== 1'b1) begin
            fails++;
            $display("FAIL final_ready: got ready=%0b, want 1", ready);
        end
        tests++;
        if (addr !== 4'hF) begin
            fails++;
            $display("FAIL final_addr: got addr=%0h, want f", addr);
        end
        tests++;
        if (data !== 8'h00) begin
            fails++;
            $display("FAIL final_data: got data=%0h, want 0", data);
        end
        tests++;
        if (err !== 1'b0) begin
            fails++;
            $display("FAIL final_err: got err=%0b, want 0", err);
        end

        while (sb.size() > 0) begin
            exp_t  x;
            string nm;
            x  = sb.pop_front();
            nm = sb_name.pop_front();
            tests++;
            fails++;
            $display("FAIL %s: expectation due at cyc %0d never checked, now cyc %0d",
                     nm, x.due, cyc);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
